// File: rtl/fault_campaign_ctrl.sv
// rtl/fault_campaign_ctrl.sv - sequences a B-range sweep over every fault location/type
// and accumulates detected/masked statistics against a golden result.
module fault_campaign_ctrl #(
  parameter int B_W   = 4,
  parameter int A_W   = 8,
  parameter int Y_W   = 8,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [A_W-1:0]   a_cfg,
  input  logic [B_W-1:0]   b_lo,
  input  logic [B_W-1:0]   b_hi,
  input  logic [Y_W-1:0]   y_in,
  output logic [B_W-1:0]   b_out,
  output logic [A_W-1:0]   a_out,
  output logic [2:0]       f_loc,
  output logic [1:0]       f_type,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] det_cnt,
  output logic [CNT_W-1:0] mask_cnt,
  output logic [7:0]       det_loc
);

  typedef enum logic [1:0] {S_IDLE, S_GOLD, S_INJ, S_DONE} state_t;

  state_t         state;
  logic [B_W-1:0] b_hi_q;
  logic [Y_W-1:0] golden;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      b_hi_q   <= '0;
      golden   <= '0;
      b_out    <= '0;
      a_out    <= '0;
      f_loc    <= '0;
      f_type   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      det_cnt  <= '0;
      mask_cnt <= '0;
      det_loc  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            det_cnt  <= '0;
            mask_cnt <= '0;
            det_loc  <= '0;
            b_hi_q   <= b_hi;
            if (a_cfg == '0 || b_lo > b_hi) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              err    <= 1'b0;
              b_out  <= b_lo;
              a_out  <= a_cfg;
              f_loc  <= '0;
              f_type <= 2'b00;
              busy   <= 1'b1;
              state  <= S_GOLD;
            end
          end
        end
        S_GOLD: begin
          golden <= y_in;
          f_loc  <= '0;
          f_type <= 2'b01;
          state  <= S_INJ;
        end
        S_INJ: begin
          // datapath is combinational, so y_in already reflects this cycle's fault
          if (y_in != golden) begin
            det_cnt          <= det_cnt + CNT_W'(1);
            det_loc[f_loc]   <= 1'b1;
          end else begin
            mask_cnt <= mask_cnt + CNT_W'(1);
          end
          if (f_type != 2'b11) begin
            f_type <= f_type + 2'd1;
          end else if (f_loc != 3'd7) begin
            f_loc  <= f_loc + 3'd1;
            f_type <= 2'b01;
          end else if (b_out == b_hi_q) begin
            // compare before increment so b_hi at full scale never wraps
            f_loc  <= '0;
            f_type <= 2'b00;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            b_out  <= b_out + B_W'(1);
            f_loc  <= '0;
            f_type <= 2'b00;
            state  <= S_GOLD;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// tb/tb_fault_campaign_ctrl.sv - table-driven and randomized checks of fault_campaign_ctrl
// against a fault-injection datapath model and an arithmetic statistics reference.
module tb_fault_campaign_ctrl;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] a_cfg;
  logic [3:0] b_lo, b_hi;
  logic [7:0] y_in;
  logic [3:0] b_out;
  logic [7:0] a_out;
  logic [2:0] f_loc;
  logic [1:0] f_type;
  logic       busy, done, err;
  logic [8:0] det_cnt, mask_cnt;
  logic [7:0] det_loc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [3:0] lo;
    logic [3:0] hi;
    logic       e;
    int         det;
    int         mask;
    logic [7:0] loc;
    int         busy;
  } vec_t;

  vec_t tbl[11];

  fault_campaign_ctrl #(.B_W(4), .A_W(8), .Y_W(8), .CNT_W(9)) dut (
    .clk(clk), .reset(reset), .start(start), .a_cfg(a_cfg), .b_lo(b_lo), .b_hi(b_hi),
    .y_in(y_in), .b_out(b_out), .a_out(a_out), .f_loc(f_loc), .f_type(f_type),
    .busy(busy), .done(done), .err(err), .det_cnt(det_cnt), .mask_cnt(mask_cnt),
    .det_loc(det_loc)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dp(input logic [3:0] b, input logic [7:0] a,
                                    input logic [2:0] loc, input logic [1:0] t);
    logic [7:0] p;
    p = {4'd0, b} * {4'd0, b};
    case (t)
      2'b01:   p[loc] = 1'b0;
      2'b10:   p[loc] = 1'b1;
      2'b11:   p[loc] = ~p[loc];
      default: ;
    endcase
    return (a == 8'd0) ? 8'd0 : p % a;
  endfunction

  always_comb y_in = dp(b_out, a_out, f_loc, f_type);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic ref_model(input logic [7:0] a, input logic [3:0] lo, input logic [3:0] hi,
                           output vec_t v);
    v.a = a; v.lo = lo; v.hi = hi;
    v.det = 0; v.mask = 0; v.loc = 8'd0; v.busy = 0;
    if (a == 8'd0 || lo > hi) begin
      v.e = 1'b1;
      return;
    end
    v.e = 1'b0;
    v.busy = 25 * (int'(hi) - int'(lo) + 1);
    for (int b = int'(lo); b <= int'(hi); b++)
      for (int k = 0; k < 8; k++)
        for (int t = 1; t <= 3; t++) begin
          int p, q;
          p = b * b;
          q = (t == 1) ? (p & ~(1 << k)) : (t == 2) ? (p | (1 << k)) : (p ^ (1 << k));
          if (q % int'(a) != p % int'(a)) begin
            v.det++;
            v.loc[k] = 1'b1;
          end else begin
            v.mask++;
          end
        end
  endtask

  task automatic run_campaign(input vec_t v, input int poke,
                              output int busy_cyc, output int done_n, output int lat,
                              output logic [4:0] done_fl);
    bit seen;
    busy_cyc = 0; done_n = 0; lat = -1; seen = 0; done_fl = '1;
    @(negedge clk);
    a_cfg = v.a; b_lo = v.lo; b_hi = v.hi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 600; n++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_n++;
        if (!seen) begin
          seen = 1; lat = n; done_fl = {f_loc, f_type};
        end
      end
      if (n == poke) begin
        start = 1'b1; a_cfg = 8'd0; b_lo = 4'd9; b_hi = 4'd1;
      end else begin
        start = 1'b0;
      end
      if (seen && n >= lat + 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic check_results(input string tag, input vec_t v, input int busy_cyc,
                               input int done_n, input int lat, input logic [4:0] done_fl);
    chk({tag, "_err"}, 64'(err), 64'(v.e));
    chk({tag, "_det_cnt"}, 64'(det_cnt), 64'(v.det));
    chk({tag, "_mask_cnt"}, 64'(mask_cnt), 64'(v.mask));
    chk({tag, "_det_loc"}, 64'(det_loc), 64'(v.loc));
    chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(v.busy));
    chk({tag, "_done_pulses"}, 64'(done_n), 64'd1);
    chk({tag, "_done_latency"}, 64'(lat), v.e ? 64'd1 : 64'(v.busy + 1));
    chk({tag, "_done_floc_ftype"}, 64'(done_fl), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    if (!v.e) chk({tag, "_b_out_end"}, 64'(b_out), 64'(v.hi));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({b_out, a_out, f_loc, f_type, busy, done, err, det_cnt, mask_cnt, det_loc});
  endfunction

  initial begin
    int bc, dn, lt, nd;
    logic [4:0] fl;
    vec_t v;

    tbl[0] = '{a: 8'd7, lo: 4'd3, hi: 4'd3,  e: 1'b0, det: 16, mask: 8,   loc: 8'hFF, busy: 25};
    tbl[1] = '{a: 8'd3, lo: 4'd0, hi: 4'd0,  e: 1'b0, det: 16, mask: 8,   loc: 8'hFF, busy: 25};
    tbl[2] = '{a: 8'd1, lo: 4'd0, hi: 4'd15, e: 1'b0, det: 0,  mask: 384, loc: 8'h00, busy: 400};
    tbl[3] = '{a: 8'd0, lo: 4'd3, hi: 4'd3,  e: 1'b1, det: 0,  mask: 0,   loc: 8'h00, busy: 0};
    tbl[4] = '{a: 8'd5, lo: 4'd5, hi: 4'd2,  e: 1'b1, det: 0,  mask: 0,   loc: 8'h00, busy: 0};
    for (int i = 5; i < 11; i++) begin
      ref_model(8'($urandom_range(1, 255)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), tbl[i]);
    end

    reset = 1'b1; start = 1'b0; a_cfg = '0; b_lo = '0; b_hi = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_state", all_outs(), 64'd0);

    for (int i = 0; i < 11; i++) begin
      run_campaign(tbl[i], -1, bc, dn, lt, fl);
      check_results($sformatf("vec%0d", i), tbl[i], bc, dn, lt, fl);
    end

    // start with a bad config mid-campaign must be ignored
    run_campaign(tbl[0], 10, bc, dn, lt, fl);
    check_results("start_while_busy", tbl[0], bc, dn, lt, fl);

    // reset during a long campaign
    @(negedge clk);
    a_cfg = 8'd7; b_lo = 4'd0; b_hi = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid_outputs", all_outs(), 64'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("reset_mid_quiet", 64'(nd), 64'd0);
    run_campaign(tbl[0], -1, bc, dn, lt, fl);
    check_results("after_reset", tbl[0], bc, dn, lt, fl);

    ref_model(8'd7, 4'd3, 4'd3, v);
    chk("model_vs_table0_det", 64'(v.det), 64'(tbl[0].det));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
